// File: rtl/alu_cc_stage_if.sv
// Handshake bus for the add/sub/cmp stage: operands and opcode strobes in, result and flags out.
interface alu_cc_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             add;
    logic             sub;
    logic             cmp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             wr_en;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic             err;

    modport master (
        output in_valid, op1, op2, add, sub, cmp, out_ready,
        input  in_ready, out_valid, result, wr_en, c, z, n, v, err
    );

    modport slave (
        input  in_valid, op1, op2, add, sub, cmp, out_ready,
        output in_ready, out_valid, result, wr_en, c, z, n, v, err
    );
endinterface

// File: rtl/alu_cc_stage.sv
// Two-stage add/sub/cmp pipeline with valid/ready on both sides and an
// architectural C/Z/N/V register that only legal ops update.
module alu_cc_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cc_stage_if.slave  bus
);
    localparam int unsigned RW = WIDTH + 1;

    // Stage 1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_op1;
    logic [WIDTH-1:0] s1_op2;
    logic             s1_add;
    logic             s1_sub;
    logic             s1_cmp;

    // Stage 2 / architectural registers
    logic             out_valid;
    logic [WIDTH:0]   result;
    logic             wr_en;
    logic             err;
    logic             c_q;
    logic             z_q;
    logic             n_q;
    logic             v_q;

    logic             s2_load_c;
    logic             in_xfer_c;
    logic             subt_c;
    logic             legal_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH:0]   sum_c;
    logic             v_c;

    assign s2_load_c = s1_valid & (~out_valid | bus.out_ready);
    assign in_xfer_c = bus.in_valid & bus.in_ready;

    // Arithmetic and flag generation from the S1 registers
    always_comb begin
        subt_c  = s1_sub | s1_cmp;
        b_c     = subt_c ? ~s1_op2 : s1_op2;
        sum_c   = {1'b0, s1_op1} + {1'b0, b_c} + RW'(subt_c);
        v_c     = (s1_op1[WIDTH-1] == b_c[WIDTH-1]) & (sum_c[WIDTH-1] != s1_op1[WIDTH-1]);
        legal_c = ({s1_add, s1_sub, s1_cmp} == 3'b100) ||
                  ({s1_add, s1_sub, s1_cmp} == 3'b010) ||
                  ({s1_add, s1_sub, s1_cmp} == 3'b001);
    end

    // S1 fills on an input transfer and empties when S2 takes its op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_add   <= 1'b0;
            s1_sub   <= 1'b0;
            s1_cmp   <= 1'b0;
        end else if (in_xfer_c) begin
            s1_valid <= 1'b1;
            s1_op1   <= bus.op1;
            s1_op2   <= bus.op2;
            s1_add   <= bus.add;
            s1_sub   <= bus.sub;
            s1_cmp   <= bus.cmp;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 output register; a load in the same edge as an output transfer replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            wr_en     <= 1'b0;
            err       <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            result    <= legal_c ? sum_c : '0;
            wr_en     <= legal_c & ~s1_cmp;
            err       <= ~legal_c;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Condition codes change only when a legal op lands in S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (s2_load_c && legal_c) begin
            c_q <= sum_c[WIDTH];
            z_q <= ~|sum_c[WIDTH-1:0];
            n_q <= sum_c[WIDTH-1];
            v_q <= v_c;
        end
    end

    assign bus.in_ready  = ~s1_valid | s2_load_c;
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.wr_en     = wr_en;
    assign bus.err       = err;
    assign bus.c         = c_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.v         = v_q;
endmodule

// File: tb/tb_alu_cc_stage.sv
// Directed-vector bench for alu_cc_stage: arithmetic/flag cases, illegal ops,
// backpressure ordering and reset while stalled.
module tb_alu_cc_stage;
    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    alu_cc_stage_if #(.WIDTH(32)) bus ();

    alu_cc_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1 and check it 2 edges later; flags = {c,z,n,v}
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] strb, input logic [32:0] e_res,
                          input logic e_wr, input logic e_err, input logic [3:0] e_flags);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.op1       = a;
        bus.op2       = b;
        {bus.add, bus.sub, bus.cmp} = strb;
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_result"}, 64'(bus.result), 64'(e_res));
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'(e_wr));
        check({tag, "_err"}, 64'(bus.err), 64'(e_err));
        check({tag, "_flags"}, 64'({bus.c, bus.z, bus.n, bus.v}), 64'(e_flags));
    endtask

    initial begin
        logic [31:0] bp_a [4];
        int          idx;
        int          k;

        n_compared    = 0;
        n_mismatched  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.add       = 1'b0;
        bus.sub       = 1'b0;
        bus.cmp       = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_wr_err", 64'({bus.wr_en, bus.err}), 64'(0));
        check("rst_flags", 64'({bus.c, bus.z, bus.n, bus.v}), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 33'h1_0000_0000, 1'b1, 1'b0, 4'b1100);
        run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 33'h0_8000_0000, 1'b1, 1'b0, 4'b0011);
        run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 3'b010, 33'h1_7FFF_FFFF, 1'b1, 1'b0, 4'b1001);
        run_op("sub_borrow", 32'h0000_0000, 32'h0000_0001, 3'b010, 33'h0_FFFF_FFFF, 1'b1, 1'b0, 4'b0010);
        run_op("cmp_eq",    32'h0000_0005, 32'h0000_0005, 3'b001, 33'h1_0000_0000, 1'b0, 1'b0, 4'b1100);
        run_op("ill_addsub", 32'h0000_0003, 32'h0000_0004, 3'b110, 33'h0, 1'b0, 1'b1, 4'b1100);
        run_op("ill_none",  32'h1234_5678, 32'h0000_0001, 3'b000, 33'h0, 1'b0, 1'b1, 4'b1100);
        run_op("add_small", 32'h0000_0002, 32'h0000_0003, 3'b100, 33'h0_0000_0005, 1'b1, 1'b0, 4'b0000);

        // Backpressure: four adds, consumer stalled for the first four cycles
        bp_a = '{32'd1, 32'd2, 32'd3, 32'd4};
        idx  = 0;
        k    = 0;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (idx < 4);
            if (idx < 4) begin
                bus.op1 = bp_a[idx];
                bus.op2 = bp_a[idx];
            end
            {bus.add, bus.sub, bus.cmp} = 3'b100;
            bus.out_ready = (cyc >= 4);
            @(negedge clk);
            if (cyc < 4)
                check($sformatf("bp_in_ready_c%0d", cyc), 64'(bus.in_ready), 64'(cyc < 2));
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bp_result_%0d", k), 64'(bus.result), 64'(2 * (k + 1)));
                check($sformatf("bp_cycle_%0d", k), 64'(cyc), 64'(4 + k));
                k++;
            end
            if (bus.in_valid && bus.in_ready)
                idx++;
            if (cyc == 3)
                check("bp_accepted", 64'(idx), 64'(2));
        end
        check("bp_all_out", 64'(k), 64'(4));

        // Drain, then fill both stages while stalled and reset mid-cycle
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op1       = 32'hFFFF_FFFF;
        bus.op2       = 32'h0000_0001;
        {bus.add, bus.sub, bus.cmp} = 3'b100;
        repeat (3) @(posedge clk);
        #1;
        check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        check("stall_flags", 64'({bus.c, bus.z, bus.n, bus.v}), 64'(4'b1100));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_flags", 64'({bus.c, bus.z, bus.n, bus.v}), 64'(0));
        check("mid_rst_result", 64'(bus.result), 64'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_no_stale_%0d", i), 64'(bus.out_valid), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
